// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_AW = 6;
  localparam int unsigned DEF_DW = 16;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_arb_select.sv
// Combinational grant selection between fetch and data requesters.
// ARB_ROUND_ROBIN_EN selects alternating grants; default is fixed data-over-fetch priority.
module arb_select
  import mem_arb_pkg::*;
(
  input  logic f_req,
  input  logic d_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    grant_valid = f_req | d_req;
    grant_id    = PORT_F;
`ifdef ARB_ROUND_ROBIN_EN
    // Contested: the port that did not win last time goes next.
    if (f_req && d_req) begin
      grant_id = ~last_grant;
    end else if (d_req) begin
      grant_id = PORT_D;
    end
`else
    if (d_req) begin
      grant_id = PORT_D;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port memory between fetch (read-only) and load/store ports, 3 cycles per access.
// Arbitration policy is set in arb_select by ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_adrs,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_adrs,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_adrs,
  output logic [DW-1:0] mem_din,
  output logic          mem_wrt,
  output logic          mem_step,
  input  logic [DW-1:0] mem_dout,
  output logic          busy,
  output logic          last_grant
);

  state_e        state_q, state_d;
  logic          port_q;
  logic          we_q;
  logic [AW-1:0] adrs_q;
  logic [DW-1:0] wdata_q;
  logic          grant_valid;
  logic          grant_id;

  arb_select u_arb_select (
    .f_req       (f_req),
    .d_req       (d_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      port_q     <= PORT_D;
      we_q       <= 1'b0;
      adrs_q     <= '0;
      wdata_q    <= '0;
      last_grant <= PORT_D;
      f_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && grant_valid) begin
        port_q     <= grant_id;
        last_grant <= grant_id;
        adrs_q     <= (grant_id == PORT_D) ? d_adrs : f_adrs;
        we_q       <= (grant_id == PORT_D) && d_we;
        if (grant_id == PORT_D) begin
          wdata_q <= d_wdata;
        end
      end
      if (state_q == ACCESS && !we_q) begin
        if (port_q == PORT_D) begin
          d_rdata <= mem_dout;
        end else begin
          f_rdata <= mem_dout;
        end
      end
    end
  end

  // Write strobes decode straight from state so an async reset kills them at once.
  always_comb begin
    mem_adrs = adrs_q;
    mem_din  = wdata_q;
    mem_wrt  = (state_q == ACCESS) && we_q;
    mem_step = (state_q == ACCESS) && we_q;
    busy     = (state_q != IDLE);
    f_ack    = (state_q == RESP) && (port_q == PORT_F);
    d_ack    = (state_q == RESP) && (port_q == PORT_D);
  end

endmodule
